snif_mbox: RTL and testbench



---
 rtl/snif_mbox.sv | 112 +++++++++++
 tb/tb_snif_mbox.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snif_mbox.sv
// snif_mbox: mailbox receiver behind the last-address write sniffer.
// Captures data written to the all-ones address and, on the sniffer's detect
// pulse, queues it in a show-ahead FIFO with a level interrupt and a sticky
// overflow flag.

`ifndef ADR_WIDTH
`define ADR_WIDTH 16
`endif

module snif_mbox #(
    parameter int unsigned ADR_WIDTH = `ADR_WIDTH,
    parameter int unsigned DAT_WIDTH = 16,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [ADR_WIDTH-1:0]       adr_i,
    input  logic [DAT_WIDTH-1:0]       dat_i,
    input  logic                       we_i,
    input  logic                       detect_i,
    input  logic                       rd_i,
    input  logic                       clr_i,
    output logic [DAT_WIDTH-1:0]       dat_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       ovf_o,
    output logic                       irq_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DAT_WIDTH-1:0] cap_q;
    logic [DAT_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]        wp_q, rp_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 irq_q;

    logic                 cap_en;
    logic                 empty, full;
    logic                 do_pop, do_push, drop;

    // Decode push/pop/drop and the next occupancy and overflow state.
    always_comb begin
        cap_en  = (&adr_i) && we_i;
        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        do_pop  = rd_i && !empty;
        // A push into a full FIFO is only accepted if a pop frees a slot this cycle.
        do_push = detect_i && (!full || do_pop);
        drop    = detect_i && full && !do_pop;

        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end

        // Set beats clear when a drop and a clear coincide.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_i) begin
            ovf_d = 1'b0;
        end
    end

    // Control state: capture register, pointers, occupancy, flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            // Push above reads the old cap_q, so back-to-back writes queue in order.
            if (cap_en) begin
                cap_q <= dat_i;
            end
            if (do_push) begin
                wp_q <= wp_q + PW'(1);
            end
            if (do_pop) begin
                rp_q <= rp_q + PW'(1);
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
            irq_q   <= (count_d != '0) || ovf_d;
        end
    end

    // Storage array; contents after reset are don't-care.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wp_q] <= cap_q;
        end
    end

    // Show-ahead outputs.
    always_comb begin
        dat_o   = empty ? '0 : mem_q[rp_q];
        valid_o = !empty;
        count_o = count_q;
        ovf_o   = ovf_q;
        irq_o   = irq_q;
    end

endmodule

// File: tb/tb_snif_mbox.sv
// Self-checking bench for snif_mbox using a queue-based reference model.
module tb_snif_mbox;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk_i  = 1'b0;
    logic          rst_ni = 1'b0;
    logic [AW-1:0] adr_i;
    logic [DW-1:0] dat_i;
    logic          we_i, detect_i, rd_i, clr_i;
    logic [DW-1:0] dat_o;
    logic          valid_o;
    logic [CW-1:0] count_o;
    logic          ovf_o, irq_o;

    int vectors = 0;
    int errors  = 0;

    logic [DW-1:0] q_m [$];
    logic [DW-1:0] cap_m;
    logic          ovf_m;

    snif_mbox #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .adr_i   (adr_i),
        .dat_i   (dat_i),
        .we_i    (we_i),
        .detect_i(detect_i),
        .rd_i    (rd_i),
        .clr_i   (clr_i),
        .dat_o   (dat_o),
        .valid_o (valid_o),
        .count_o (count_o),
        .ovf_o   (ovf_o),
        .irq_o   (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        adr_i = '0; dat_i = '0; we_i = 1'b0;
        detect_i = 1'b0; rd_i = 1'b0; clr_i = 1'b0;
    endtask

    // Advance the model by one clock from the current inputs, then clock the DUT.
    task automatic tick();
        bit pop, full;
        pop  = rd_i && (q_m.size() != 0);
        full = (q_m.size() == DEPTH);
        if (detect_i && full && !pop) ovf_m = 1'b1;
        else if (clr_i) ovf_m = 1'b0;
        if (pop) void'(q_m.pop_front());
        if (detect_i && (!full || pop)) q_m.push_back(cap_m);
        if ((&adr_i) && we_i) cap_m = dat_i;
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_reset();
        q_m.delete();
        cap_m = '0;
        ovf_m = 1'b0;
    endtask

    task automatic mbox_write(input logic [DW-1:0] d);
        adr_i = '1; we_i = 1'b1; dat_i = d;
        tick();
        adr_i = '0; we_i = 1'b0; dat_i = '0;
    endtask

    task automatic write_push(input logic [DW-1:0] d);
        mbox_write(d);
        detect_i = 1'b1;
        tick();
        detect_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        vectors++;
        if ({valid_o, irq_o, ovf_o, count_o, dat_o} !== '0) begin
            errors++;
            $display("FAIL reset_initial: got valid=%b irq=%b ovf=%b count=%0d dat=%h, want all 0",
                     valid_o, irq_o, ovf_o, count_o, dat_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        write_push(16'h1234);
        write_push(16'h5678);
        vectors++;
        if (count_o !== 3'd2) begin
            errors++;
            $display("FAIL reset_prefill: count=%0d want 2", count_o);
        end
        // Assert reset mid-cycle; outputs must clear before the next edge.
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({valid_o, irq_o, ovf_o, count_o, dat_o} !== '0) begin
            errors++;
            $display("FAIL reset_async: got valid=%b irq=%b ovf=%b count=%0d dat=%h, want all 0",
                     valid_o, irq_o, ovf_o, count_o, dat_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        rd_i = 1'b1;
        tick();
        tick();
        rd_i = 1'b0;
        vectors++;
        if (count_o !== 3'd0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_empty: count=%0d valid=%b want 0 0", count_o, valid_o);
        end
    endtask

    task automatic test_single();
        mbox_write(16'hBEEF);
        tick();
        vectors++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_early: valid=%b want 0", valid_o);
        end
        detect_i = 1'b1;
        tick();
        detect_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b1 || irq_o !== 1'b1 || dat_o !== 16'hBEEF || count_o !== 3'd1) begin
            errors++;
            $display("FAIL single_visible: valid=%b irq=%b dat=%h count=%0d want 1 1 beef 1",
                     valid_o, irq_o, dat_o, count_o);
        end
        rd_i = 1'b1;
        tick();
        rd_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b0 || irq_o !== 1'b0 || dat_o !== 16'h0) begin
            errors++;
            $display("FAIL single_pop: valid=%b irq=%b dat=%h want 0 0 0000", valid_o, irq_o, dat_o);
        end
    endtask

    task automatic test_order_wrap();
        logic [DW-1:0] exp_seq [6];
        exp_seq = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6};
        for (int i = 1; i <= 4; i++) write_push(DW'(i));
        vectors++;
        if (count_o !== 3'd4) begin
            errors++;
            $display("FAIL order_fill: count=%0d want 4", count_o);
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (dat_o !== exp_seq[i]) begin
                errors++;
                $display("FAIL order_pop%0d: dat=%h want %h", i, dat_o, exp_seq[i]);
            end
            rd_i = 1'b1; tick(); rd_i = 1'b0;
        end
        write_push(16'h5);
        write_push(16'h6);
        for (int i = 2; i < 6; i++) begin
            vectors++;
            if (dat_o !== exp_seq[i]) begin
                errors++;
                $display("FAIL wrap_pop%0d: dat=%h want %h", i, dat_o, exp_seq[i]);
            end
            rd_i = 1'b1; tick(); rd_i = 1'b0;
        end
        vectors++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_empty: valid=%b want 0", valid_o);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) write_push(DW'(i));
        vectors++;
        if (count_o !== 3'd4 || ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop: count=%0d ovf=%b want 4 1", count_o, ovf_o);
        end
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if (dat_o !== DW'(i)) begin
                errors++;
                $display("FAIL ovf_drain%0d: dat=%h want %h", i, dat_o, DW'(i));
            end
            rd_i = 1'b1; tick(); rd_i = 1'b0;
        end
        vectors++;
        if (valid_o !== 1'b0 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_irq_hold: valid=%b irq=%b want 0 1", valid_o, irq_o);
        end
        clr_i = 1'b1; tick(); clr_i = 1'b0;
        vectors++;
        if (irq_o !== 1'b0 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: irq=%b ovf=%b want 0 0", irq_o, ovf_o);
        end
        for (int i = 1; i <= 4; i++) write_push(DW'(8'h20 + i));
        mbox_write(16'h0099);
        detect_i = 1'b1; clr_i = 1'b1;
        tick();
        detect_i = 1'b0; clr_i = 1'b0;
        vectors++;
        if (ovf_o !== 1'b1 || count_o !== 3'd4) begin
            errors++;
            $display("FAIL ovf_set_wins: ovf=%b count=%0d want 1 4", ovf_o, count_o);
        end
        rd_i = 1'b1; clr_i = 1'b1;
        repeat (4) tick();
        rd_i = 1'b0; clr_i = 1'b0;
    endtask

    task automatic test_full_rdpush();
        logic [DW-1:0] exp_seq [4];
        exp_seq = '{16'h11, 16'h12, 16'h13, 16'h77};
        for (int i = 0; i < 4; i++) write_push(DW'(16'h10 + i));
        mbox_write(16'h0077);
        detect_i = 1'b1; rd_i = 1'b1;
        tick();
        detect_i = 1'b0; rd_i = 1'b0;
        vectors++;
        if (count_o !== 3'd4 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL full_rdpush: count=%0d ovf=%b want 4 0", count_o, ovf_o);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (dat_o !== exp_seq[i]) begin
                errors++;
                $display("FAIL full_rdpush_drain%0d: dat=%h want %h", i, dat_o, exp_seq[i]);
            end
            rd_i = 1'b1; tick(); rd_i = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        // Empty FIFO, rd and detect together: pop ignored, push lands.
        mbox_write(16'hA0A0);
        adr_i = '1; we_i = 1'b1; dat_i = 16'hB1B1; detect_i = 1'b1; rd_i = 1'b1;
        tick();
        adr_i = '0; we_i = 1'b0; dat_i = '0; rd_i = 1'b0;
        tick();
        detect_i = 1'b0;
        vectors++;
        if (count_o !== 3'd2 || dat_o !== 16'hA0A0) begin
            errors++;
            $display("FAIL b2b_first: count=%0d dat=%h want 2 a0a0", count_o, dat_o);
        end
        rd_i = 1'b1; tick(); rd_i = 1'b0;
        vectors++;
        if (dat_o !== 16'hB1B1) begin
            errors++;
            $display("FAIL b2b_second: dat=%h want b1b1", dat_o);
        end
        rd_i = 1'b1; tick(); rd_i = 1'b0;
    endtask

    task automatic test_non_mailbox();
        adr_i = 16'hFFFE; we_i = 1'b1; dat_i = 16'hAAAA; tick();
        adr_i = 16'hFFFF; we_i = 1'b0; dat_i = 16'h5555; tick();
        idle();
        tick();
        vectors++;
        if (count_o !== 3'd0) begin
            errors++;
            $display("FAIL nonmbox_nopush: count=%0d want 0", count_o);
        end
        detect_i = 1'b1; tick(); detect_i = 1'b0;
        vectors++;
        if (dat_o !== 16'hB1B1) begin
            errors++;
            $display("FAIL nonmbox_cap: dat=%h want b1b1", dat_o);
        end
        rd_i = 1'b1; tick(); rd_i = 1'b0;
        adr_i = '1; we_i = 1'b1;
        dat_i = 16'h11; tick();
        dat_i = 16'h22; tick();
        dat_i = 16'h33; tick();
        idle();
        detect_i = 1'b1; tick(); detect_i = 1'b0;
        vectors++;
        if (dat_o !== 16'h33) begin
            errors++;
            $display("FAIL multibeat: dat=%h want 0033", dat_o);
        end
        rd_i = 1'b1; tick(); rd_i = 1'b0;
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_dat;
        for (int n = 0; n < 2000; n++) begin
            adr_i    = ($urandom_range(0, 1) == 1) ? '1 : AW'($urandom);
            we_i     = 1'($urandom);
            dat_i    = DW'($urandom);
            detect_i = ($urandom_range(0, 9) < 4);
            rd_i     = ($urandom_range(0, 9) < 4);
            clr_i    = ($urandom_range(0, 9) == 0);
            tick();
            exp_dat = (q_m.size() != 0) ? q_m[0] : '0;
            vectors++;
            if (count_o !== CW'(q_m.size()) || valid_o !== (q_m.size() != 0)) begin
                errors++;
                $display("FAIL rand_count@%0d: count=%0d valid=%b want %0d %b",
                         n, count_o, valid_o, q_m.size(), q_m.size() != 0);
            end
            vectors++;
            if (dat_o !== exp_dat) begin
                errors++;
                $display("FAIL rand_dat@%0d: dat=%h want %h", n, dat_o, exp_dat);
            end
            vectors++;
            if (ovf_o !== ovf_m || irq_o !== ((q_m.size() != 0) || ovf_m)) begin
                errors++;
                $display("FAIL rand_flags@%0d: ovf=%b irq=%b want %b %b",
                         n, ovf_o, irq_o, ovf_m, (q_m.size() != 0) || ovf_m);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single();
        test_order_wrap();
        test_overflow();
        test_full_rdpush();
        test_back_to_back();
        test_non_mailbox();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
